// File: rtl/ctrl_types_pkg.sv
// Operation codes and controller state encoding for the key-value engine.
package ctrl_types_pkg;
    typedef enum logic [1:0] {
        NOOP = 2'd0,
        GET  = 2'd1,
        PUT  = 2'd2,
        DEL  = 2'd3
    } operation_e;

    typedef enum logic [1:0] {
        CTRL_ST_IDLE,
        CTRL_ST_SEARCH,
        CTRL_ST_RESP,
        CTRL_ST_WAIT
    } ctrl_state_e;
endpackage

// File: rtl/if_types_pkg.sv
// Widths shared with the upstream OBI cache interface.
package if_types_pkg;
    localparam int KEY_WIDTH   = 32;
    localparam int VALUE_WIDTH = 64;
endpackage

// File: rtl/cache_controller_if.sv
// Request/response bundle between the OBI cache interface and the KV engine.
interface cache_controller_if #(
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
    parameter int CNT_W       = 4
) ();
    ctrl_types_pkg::operation_e operation_in;
    logic [KEY_WIDTH-1:0]       key_in;
    logic [VALUE_WIDTH-1:0]     value_in;
    logic                       ready_out;
    logic                       op_succ_out;
    logic [VALUE_WIDTH-1:0]     value_out;
    logic [CNT_W-1:0]           entry_count_out;

    modport master (
        output operation_in, key_in, value_in,
        input  ready_out, op_succ_out, value_out, entry_count_out
    );

    modport slave (
        input  operation_in, key_in, value_in,
        output ready_out, op_succ_out, value_out, entry_count_out
    );
endinterface

// File: rtl/kv_entry_table.sv
// Fully-associative key/value storage with one compare/read port and one write port.
module kv_entry_table #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDX_W-1:0]       rd_idx,
    input  logic [KEY_WIDTH-1:0]   cmp_key,
    output logic                   hit,
    output logic                   entry_valid,
    output logic [VALUE_WIDTH-1:0] rd_value,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [KEY_WIDTH-1:0]   wr_key,
    input  logic [VALUE_WIDTH-1:0] wr_value,
    input  logic                   clr_en,
    input  logic [IDX_W-1:0]       clr_idx
);
    logic [NUM_ENTRIES-1:0] valid;
    logic [KEY_WIDTH-1:0]   keys   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] values [NUM_ENTRIES];

    assign entry_valid = valid[rd_idx];
    assign hit         = valid[rd_idx] && (keys[rd_idx] == cmp_key);
    assign rd_value    = values[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (wr_en)  valid[wr_idx]  <= 1'b1;
            if (clr_en) valid[clr_idx] <= 1'b0;
        end
    end

    // Key/value payload is never reset; the valid bits alone define table contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            keys[wr_idx]   <= wr_key;
            values[wr_idx] <= wr_value;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// GET/PUT/DEL engine: linear one-entry-per-cycle search, single-cycle ready pulse.
module cache_controller
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    cache_controller_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    ctrl_state_e            state;
    operation_e             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [IDX_W-1:0]       idx;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   ready_q;
    logic                   succ_q;
    logic [VALUE_WIDTH-1:0] result_q;
    logic [CNT_W-1:0]       count_q;

    logic                   hit, entry_valid;
    logic [VALUE_WIDTH-1:0] rd_value;
    logic                   resolve, free_avail, wr_en, clr_en;
    logic [IDX_W-1:0]       wr_idx;

    kv_entry_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_WIDTH   (KEY_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (idx),
        .cmp_key     (key_q),
        .hit         (hit),
        .entry_valid (entry_valid),
        .rd_value    (rd_value),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_key      (key_q),
        .wr_value    (value_q),
        .clr_en      (clr_en),
        .clr_idx     (idx)
    );

    // The search resolves on a hit or on the last slot; table updates commit on that edge
    // so the result, the new table contents and the count all appear with the ready pulse.
    always_comb begin
        resolve    = (state == CTRL_ST_SEARCH) && (hit || (idx == IDX_W'(NUM_ENTRIES - 1)));
        free_avail = free_found || !entry_valid;
        wr_idx     = hit ? idx : (free_found ? free_idx : idx);
        wr_en      = resolve && (op_q == PUT) && (hit || free_avail);
        clr_en     = resolve && (op_q == DEL) && hit;
    end

    always_ff @(posedge clk) begin
        if (state == CTRL_ST_IDLE && bus.operation_in != NOOP) begin
            key_q   <= bus.key_in;
            value_q <= bus.value_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CTRL_ST_IDLE;
            op_q       <= NOOP;
            idx        <= '0;
            free_found <= 1'b0;
            free_idx   <= '0;
            ready_q    <= 1'b0;
            succ_q     <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
        end else begin
            case (state)
                CTRL_ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.operation_in != NOOP) begin
                        op_q       <= bus.operation_in;
                        idx        <= '0;
                        free_found <= 1'b0;
                        state      <= CTRL_ST_SEARCH;
                    end
                end
                CTRL_ST_SEARCH: begin
                    if (!entry_valid && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (resolve) begin
                        ready_q  <= 1'b1;
                        succ_q   <= hit || ((op_q == PUT) && free_avail);
                        result_q <= hit ? rd_value : '0;
                        if (op_q == PUT && !hit && free_avail) count_q <= count_q + CNT_W'(1);
                        if (op_q == DEL && hit)                count_q <= count_q - CNT_W'(1);
                        state <= CTRL_ST_RESP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                CTRL_ST_RESP: begin
                    ready_q <= 1'b0;
                    state   <= CTRL_ST_WAIT;
                end
                CTRL_ST_WAIT: begin
                    if (bus.operation_in == NOOP) state <= CTRL_ST_IDLE;
                end
                default: state <= CTRL_ST_IDLE;
            endcase
        end
    end

    assign bus.ready_out       = ready_q;
    assign bus.op_succ_out     = succ_q;
    assign bus.value_out       = result_q;
    assign bus.entry_count_out = count_q;
endmodule

// File: tb/tb_cache_controller.sv
// Randomized and directed bench for cache_controller against an array-based table model.
module tb_cache_controller;
    import ctrl_types_pkg::*;

    localparam int N  = 8;
    localparam int KW = if_types_pkg::KEY_WIDTH;
    localparam int VW = if_types_pkg::VALUE_WIDTH;
    localparam int CW = $clog2(N) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cache_controller_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_W(CW)) bus ();

    cache_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [KW-1:0] m_key [N];
    logic [VW-1:0] m_val [N];
    bit            m_vld [N];
    int            m_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_count = 0;
    endtask

    // Table semantics: first matching slot is the hit, first empty slot takes a new key.
    task automatic model_exec(input operation_e op, input logic [KW-1:0] key,
                              input logic [VW-1:0] val, output bit succ,
                              output logic [VW-1:0] res, output int lat);
        int hit_i  = -1;
        int free_i = -1;
        for (int i = 0; i < N; i++)
            if (hit_i < 0 && m_vld[i] && m_key[i] == key) hit_i = i;
        for (int i = 0; i < N; i++)
            if (free_i < 0 && !m_vld[i]) free_i = i;
        lat  = (hit_i >= 0) ? hit_i + 2 : N + 1;
        succ = (hit_i >= 0);
        res  = (hit_i >= 0) ? m_val[hit_i] : '0;
        case (op)
            PUT: begin
                if (hit_i >= 0) begin
                    m_val[hit_i] = val;
                end else if (free_i >= 0) begin
                    m_key[free_i] = key;
                    m_val[free_i] = val;
                    m_vld[free_i] = 1'b1;
                    m_count++;
                    succ = 1'b1;
                end
            end
            DEL: begin
                if (hit_i >= 0) begin
                    m_vld[hit_i] = 1'b0;
                    m_count--;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input operation_e op,
                          input logic [KW-1:0] key, input logic [VW-1:0] val);
        bit            es;
        logic [VW-1:0] ev;
        int            el;
        int            lat  = 0;
        bit            seen = 1'b0;
        model_exec(op, key, val, es, ev, el);
        @(negedge clk);
        bus.operation_in = op;
        bus.key_in       = key;
        bus.value_in     = val;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.key_in   = ~key;
                bus.value_in = {$urandom(), $urandom()};
            end
            if (bus.ready_out) seen = 1'b1;
        end
        check({tag, "_ready"}, 64'(seen), 64'(1));
        check({tag, "_lat"},   64'(lat), 64'(el));
        check({tag, "_succ"},  64'(bus.op_succ_out), 64'(es));
        check({tag, "_value"}, bus.value_out, ev);
        check({tag, "_count"}, 64'(bus.entry_count_out), 64'(m_count));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.ready_out), 64'(0));
        check({tag, "_hold"},  bus.value_out, ev);
        bus.operation_in = NOOP;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        bus.operation_in = NOOP;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.ready_out), 64'(0));
        check("rst_succ",  64'(bus.op_succ_out), 64'(0));
        check("rst_value", bus.value_out, 64'(0));
        check("rst_count", 64'(bus.entry_count_out), 64'(0));
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        bus.operation_in = NOOP;
        bus.key_in       = '0;
        bus.value_in     = '0;
        model_clear();
        apply_reset();

        run_op("get_empty", GET, 32'h12, '0);
        run_op("put_new",   PUT, 32'h12, 64'hDEADBEEF_00000001);
        run_op("get_hit",   GET, 32'h12, '0);
        run_op("put_upd",   PUT, 32'h12, 64'h5);
        run_op("get_upd",   GET, 32'h12, '0);

        apply_reset();
        for (int k = 1; k <= N; k++) run_op("fill", PUT, KW'(k), {32'hCAFE0000, 32'(k)});
        run_op("put_full",  PUT, 32'h9, 64'h99);
        run_op("get_ninth", GET, 32'h9, '0);
        run_op("del_k3",    DEL, 32'h3, '0);
        run_op("put_ninth", PUT, 32'h9, 64'h99);
        run_op("get_slot2", GET, 32'h9, '0);
        run_op("del_miss",  DEL, 32'h3, '0);

        // Request held high long after completion must execute once only.
        @(negedge clk);
        bus.operation_in = GET;
        bus.key_in       = 32'h9;
        pulses = 0;
        for (int c = 0; c < 20 + N + 1; c++) begin
            @(negedge clk);
            if (bus.ready_out) pulses++;
        end
        check("hold_pulses", 64'(pulses), 64'(1));
        check("hold_value",  bus.value_out, 64'h99);
        bus.operation_in = NOOP;
        repeat (2) @(negedge clk);
        run_op("after_hold", GET, 32'h1, '0);

        // Reset in the middle of a PUT search.
        run_op("pre_rst", PUT, 32'h40, 64'h4040);
        @(negedge clk);
        bus.operation_in = PUT;
        bus.key_in       = 32'h77;
        bus.value_in     = 64'h7777;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ready_out) pulses++;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ready_out) pulses++;
        end
        bus.operation_in = NOOP;
        rst_n            = 1'b1;
        repeat (N + 3) begin
            @(negedge clk);
            if (bus.ready_out) pulses++;
        end
        check("midrst_pulses", 64'(pulses), 64'(0));
        check("midrst_count",  64'(bus.entry_count_out), 64'(0));
        model_clear();
        run_op("midrst_get", GET, 32'h77, '0);

        for (int n = 0; n < 150; n++) begin
            operation_e op = operation_e'($urandom_range(1, 3));
            run_op("rand", op, KW'($urandom_range(1, 11)), {$urandom(), $urandom()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
